// File: rtl/clk_div_meter_if.sv
// Bus bundle for clk_div_meter: clock-under-test and enable in, measured
// divider encoding, period, publish strobe and stall flag out.
interface clk_div_meter_if #(
    parameter int CCntW = 8
);
    logic                 AClkHEn;
    logic                 AClkM;
    logic [2*CCntW-1:0]   ADivider;
    logic [CCntW:0]       APeriod;
    logic                 AValid;
    logic                 AStall;

    modport master (
        output AClkHEn,
        output AClkM,
        input  ADivider,
        input  APeriod,
        input  AValid,
        input  AStall
    );

    modport slave (
        input  AClkHEn,
        input  AClkM,
        output ADivider,
        output APeriod,
        output AValid,
        output AStall
    );
endinterface

// File: rtl/clk_div_meter.sv
// Measures high/low phase lengths of an asynchronous clock in enabled AClkH
// cycles and publishes them as {high-1, low-1} plus the full period.
module clk_div_meter #(
    parameter int CCntW    = 8,
    parameter int CSyncLen = 2
) (
    input  logic             AClkH,
    input  logic             AResetHN,
    clk_div_meter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MEAS_HIGH = 2'd1,
        ST_MEAS_LOW  = 2'd2
    } state_t;

    localparam logic [CCntW-1:0] CntOne    = {{(CCntW-1){1'b0}}, 1'b1};
    localparam logic [CCntW:0]   PeriodTwo = {{(CCntW-1){1'b0}}, 2'b10};

    logic [CSyncLen-1:0]  sync_q,   sync_d;
    logic                 prev_q,   prev_d;
    state_t               state_q,  state_d;
    logic [CCntW-1:0]     cnt_q,    cnt_d;
    logic [CCntW-1:0]     high_q,   high_d;
    logic [2*CCntW-1:0]   div_q,    div_d;
    logic [CCntW:0]       period_q, period_d;
    logic                 valid_q,  valid_d;
    logic                 stall_q,  stall_d;

    logic                 level_s;
    logic                 rise_s;
    logic                 fall_s;
    logic                 sat_s;

    // Next-state logic: edge detection on the synchronized level plus the phase FSM.
    always_comb begin
        level_s  = sync_q[CSyncLen-1];
        rise_s   = level_s & ~prev_q;
        fall_s   = ~level_s & prev_q;
        sat_s    = (cnt_q == {CCntW{1'b1}});

        sync_d   = {sync_q[CSyncLen-2:0], bus.AClkM};
        prev_d   = level_s;
        state_d  = state_q;
        cnt_d    = cnt_q;
        high_d   = high_q;
        div_d    = div_q;
        period_d = period_q;
        valid_d  = 1'b0;
        stall_d  = stall_q;

        case (state_q)
            ST_IDLE: begin
                // Partial period after reset/stall is discarded: only a Rise starts a measurement.
                cnt_d = {CCntW{1'b0}};
                if (rise_s) begin
                    state_d = ST_MEAS_HIGH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEAS_HIGH: begin
                if (fall_s) begin
                    high_d  = cnt_q;
                    cnt_d   = {CCntW{1'b0}};
                    state_d = ST_MEAS_LOW;
                end else if (sat_s && !rise_s) begin
                    stall_d = 1'b1;
                    cnt_d   = {CCntW{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + CntOne;
                end
            end
            ST_MEAS_LOW: begin
                if (rise_s) begin
                    div_d    = {high_q, cnt_q};
                    period_d = {1'b0, high_q} + {1'b0, cnt_q} + PeriodTwo;
                    valid_d  = 1'b1;
                    stall_d  = 1'b0;
                    cnt_d    = {CCntW{1'b0}};
                    state_d  = ST_MEAS_HIGH;
                end else if (sat_s && !fall_s) begin
                    stall_d = 1'b1;
                    cnt_d   = {CCntW{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + CntOne;
                end
            end
            default: begin
                cnt_d   = {CCntW{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; frozen whenever the host clock enable is low.
    always_ff @(posedge AClkH or negedge AResetHN) begin
        if (!AResetHN) begin
            sync_q   <= {CSyncLen{1'b0}};
            prev_q   <= 1'b0;
            state_q  <= ST_IDLE;
            cnt_q    <= {CCntW{1'b0}};
            high_q   <= {CCntW{1'b0}};
            div_q    <= {(2*CCntW){1'b0}};
            period_q <= {(CCntW+1){1'b0}};
            valid_q  <= 1'b0;
            stall_q  <= 1'b0;
        end else if (bus.AClkHEn) begin
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            high_q   <= high_d;
            div_q    <= div_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            stall_q  <= stall_d;
        end
    end

    assign bus.ADivider = div_q;
    assign bus.APeriod  = period_q;
    assign bus.AValid   = valid_q;
    assign bus.AStall   = stall_q;

endmodule

// File: tb/tb_clk_div_meter.sv
// Directed bench for clk_div_meter: reset, steady state, divider change,
// stall/recovery, clock enable and reset during measurement.
module tb_clk_div_meter;

    logic AClkH;
    logic AResetHN;

    clk_div_meter_if #(.CCntW(8)) bus ();

    clk_div_meter #(.CCntW(8), .CSyncLen(2)) dut (
        .AClkH    (AClkH),
        .AResetHN (AResetHN),
        .bus      (bus.slave)
    );

    int checks     = 0;
    int failures   = 0;
    int pulses     = 0;
    int hi_cycles  = 0;
    int odd        = 0;
    logic valid_prev = 1'b0;

    initial AClkH = 1'b0;
    always #5 AClkH = ~AClkH;

    // Publish monitor: counts AValid rising edges, high samples and unexpected values.
    always @(negedge AClkH) begin
        if (bus.AValid && !valid_prev) begin
            pulses = pulses + 1;
            if (bus.ADivider != 16'h0305 && bus.ADivider != 16'h0101)
                odd = odd + 1;
        end
        if (bus.AValid)
            hi_cycles = hi_cycles + 1;
        valid_prev = bus.AValid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives n periods of AClkM (hi/lo raw AClkH cycles); alt toggles the enable each cycle.
    task automatic run_clk(input int hi, input int lo, input int n, input bit alt);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < hi + lo; i++) begin
                bus.AClkM   = (i < hi);
                bus.AClkHEn = alt ? ~bus.AClkHEn : 1'b1;
                @(negedge AClkH);
            end
        end
    endtask

    initial begin
        AResetHN    = 1'b0;
        bus.AClkM   = 1'b0;
        bus.AClkHEn = 1'b1;
        repeat (3) @(negedge AClkH);
        check("rst_div",    32'(bus.ADivider), 32'h0);
        check("rst_period", 32'(bus.APeriod),  32'h0);
        check("rst_valid",  32'(bus.AValid),   32'h0);
        check("rst_stall",  32'(bus.AStall),   32'h0);

        run_clk(4, 6, 2, 1'b0);
        check("rst_hold_div", 32'(bus.ADivider), 32'h0);

        // First period after release must be discarded.
        AResetHN = 1'b1;
        pulses = 0;
        run_clk(4, 6, 1, 1'b0);
        check("first_rise_no_valid", 32'(pulses), 32'd0);
        check("first_rise_div",      32'(bus.ADivider), 32'h0);
        run_clk(4, 6, 1, 1'b0);
        check("first_pub_cnt",    32'(pulses), 32'd1);
        check("first_pub_div",    32'(bus.ADivider), 32'h0305);
        check("first_pub_period", 32'(bus.APeriod), 32'd10);

        // Steady state 4/6.
        run_clk(4, 6, 3, 1'b0);
        pulses = 0;
        hi_cycles = 0;
        run_clk(4, 6, 3, 1'b0);
        check("steady_pulses", 32'(pulses), 32'd3);
        check("steady_width",  32'(hi_cycles), 32'd3);
        check("steady_div",    32'(bus.ADivider), 32'h0305);
        check("steady_period", 32'(bus.APeriod), 32'd10);
        check("steady_stall",  32'(bus.AStall), 32'h0);

        // Switch to 2/2 on the fly.
        odd = 0;
        run_clk(2, 2, 3, 1'b0);
        check("chg_div",    32'(bus.ADivider), 32'h0101);
        check("chg_period", 32'(bus.APeriod), 32'd4);
        check("chg_stall",  32'(bus.AStall), 32'h0);
        check("chg_mixed_le1", 32'(odd <= 1), 32'h1);

        // Stall: hold AClkM high well past counter saturation.
        run_clk(4, 6, 3, 1'b0);
        check("pre_stall_div", 32'(bus.ADivider), 32'h0305);
        bus.AClkM = 1'b1;
        repeat (5) @(negedge AClkH);
        pulses = 0;
        repeat (200) @(negedge AClkH);
        check("stall_early", 32'(bus.AStall), 32'h0);
        repeat (195) @(negedge AClkH);
        check("stall_set",    32'(bus.AStall), 32'h1);
        check("stall_pulses", 32'(pulses), 32'd0);
        check("stall_div",    32'(bus.ADivider), 32'h0305);
        check("stall_period", 32'(bus.APeriod), 32'd10);
        run_clk(4, 6, 2, 1'b0);
        check("stall_sticky",        32'(bus.AStall), 32'h1);
        check("stall_no_early_pub",  32'(pulses), 32'd0);
        run_clk(4, 6, 2, 1'b0);
        check("stall_clear",  32'(bus.AStall), 32'h0);
        check("recover_div",  32'(bus.ADivider), 32'h0305);
        check("recover_cnt",  32'(pulses), 32'd2);

        // Clock enable every other cycle, 8/8 raw cycles.
        run_clk(8, 8, 4, 1'b1);
        pulses = 0;
        run_clk(8, 8, 2, 1'b1);
        check("en_div",    32'(bus.ADivider), 32'h0303);
        check("en_period", 32'(bus.APeriod), 32'd8);
        check("en_pulses", 32'(pulses), 32'd2);

        // Reset while in the low phase.
        run_clk(4, 6, 3, 1'b0);
        bus.AClkM = 1'b1;
        repeat (4) @(negedge AClkH);
        bus.AClkM = 1'b0;
        repeat (3) @(negedge AClkH);
        AResetHN = 1'b0;
        #1;
        check("midrst_div",    32'(bus.ADivider), 32'h0);
        check("midrst_period", 32'(bus.APeriod), 32'h0);
        check("midrst_valid",  32'(bus.AValid), 32'h0);
        check("midrst_stall",  32'(bus.AStall), 32'h0);
        repeat (2) @(negedge AClkH);
        AResetHN = 1'b1;
        pulses = 0;
        run_clk(4, 6, 1, 1'b0);
        check("midrst_first_none", 32'(pulses), 32'd0);
        check("midrst_first_div",  32'(bus.ADivider), 32'h0);
        run_clk(4, 6, 1, 1'b0);
        check("midrst_pub_cnt", 32'(pulses), 32'd1);
        check("midrst_pub_div", 32'(bus.ADivider), 32'h0305);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_div_meter.md
Name: clk_div_meter

Overview:
- Measures an incoming clock (typically the output of a programmable clock divider) against AClkH.
- Reports the high and low phase lengths in the same divider encoding the generator uses, {high-1, low-1}, so software can read back the effective divider and compare it with the programmed one.
- Sits in the AClkH (host) domain; the measured clock is treated as an asynchronous data input.

Parameters:
- CCntW, 8: phase counter width; also the width of each half of ADivider.
- CSyncLen, 2: number of synchronizer flops for AClkM, minimum 2.

Ports:
- AClkH  input  1  host clock.
- AResetHN  input  1  asynchronous reset, active-low.
- AClkHEn  input  1  host clock enable; all state frozen when low.
- AClkM  input  1  clock under measurement, asynchronous to AClkH.
- ADivider  output  2*CCntW  last measured {HighME, LowME}; each field is phase length in enabled AClkH cycles minus 1.
- APeriod  output  CCntW+1  HighME+LowME+2, the full period in enabled AClkH cycles.
- AValid  output  1  one-cycle pulse when ADivider/APeriod update.
- AStall  output  1  sticky flag: measured clock stopped (phase counter saturated).

Behaviour:
- Reset (AResetHN=0, async):
  - ADivider=0, APeriod=0, AValid=0, AStall=0.
  - Synchronizer chain and previous-level flop = 0.
  - Phase counter = 0, captured high = 0, state = Idle.
- Clock enable: every register, synchronizer included, updates only when AClkHEn=1. Counts are therefore in enabled cycles.
- Synchronizer:
  - AClkM passes through CSyncLen flops; the last flop gives level L. A further flop gives P.
  - Rise = L & ~P; Fall = ~L & P.
  - Each AClkM phase must last at least 2 enabled AClkH cycles; shorter phases are not guaranteed to be detected.
- States:
  - Idle: counter held 0. On Rise, go to MeasHigh with counter=0. No publish.
  - MeasHigh:
    - On Fall: captured high ← counter, counter ← 0, go to MeasLow.
    - Otherwise: counter ← counter+1.
  - MeasLow:
    - On Rise: ADivider ← {captured high, counter}; APeriod ← captured high + counter + 2 (CCntW+1 bits, no overflow possible); AValid=1 next cycle; AStall ← 0; counter ← 0; go to MeasHigh.
    - Otherwise: counter ← counter+1.
- Latency: AValid and the new ADivider appear on the same cycle, the enabled cycle after the Rise detect. That is CSyncLen+1 enabled cycles after the AClkM rising edge is sampled.
- Stall:
  - In MeasHigh or MeasLow, if counter == all-ones and no edge is detected that cycle: AStall ← 1, state ← Idle, counter ← 0.
  - ADivider and APeriod hold their last values.
  - AValid is not pulsed.
- AStall is sticky until the next publish. It is cleared in the same cycle AValid rises.
- After a stall or reset, the first partial period is discarded. The first publish needs Rise → Fall → Rise.
- Edge precedence: Rise and Fall are mutually exclusive by construction. In the saturation cycle, an edge wins over stall.
- AValid is exactly one enabled cycle wide. If AClkHEn=0 in the following cycle, AValid holds until the next enabled cycle.
- Reset mid-measurement: everything returns to reset values at once. No publish of partial data.

Test Plan:
- Reset / first period:
  - Hold reset, then release with AClkM running.
  - Outputs stay 0 until the first full Rise-Fall-Rise.
  - No AValid on the first Rise after reset.
- Steady state, CCntW=8:
  - AClkM high 4 and low 6 AClkH cycles, AClkHEn=1.
  - ADivider=16'h0305, APeriod=10.
  - AValid pulses every 10 cycles, AStall=0.
- Divider change on the fly:
  - Switch AClkM to high 2 / low 2 mid-run.
  - Within two periods ADivider=16'h0101, APeriod=4, with no stall.
  - At most one intermediate mixed value is published.
- Stall:
  - Hold AClkM high for 400 cycles after a valid 16'h0305.
  - AStall=1 when the counter saturates at 8'hFF, about 256 cycles after the Rise.
  - ADivider stays 16'h0305; no AValid.
  - Restart AClkM at 4/6: AStall clears with the next AValid, ADivider=16'h0305.
- Clock enable:
  - AClkHEn asserted every other cycle, AClkM high 8 / low 8 raw AClkH cycles.
  - ADivider=16'h0303, APeriod=8.
- Reset mid-operation:
  - Assert AResetHN=0 in MeasLow.
  - All outputs go to 0 immediately.
  - After release, the next publish needs a full Rise-Fall-Rise.
